// File: rtl/mir_pkg.sv
// Shared definitions for the microinstruction sequencer: MIR field layout,
// bus "none" selects, the NOP word, Ttype condition/force codes and FSM states.
package mir_pkg;

  localparam int MIR_W   = 33;

  localparam int ALU_HI  = 32;
  localparam int ALU_LO  = 29;
  localparam int SH_HI   = 28;
  localparam int SH_LO   = 27;
  localparam int KMX_BIT = 26;
  localparam int MR_BIT  = 25;
  localparam int MW_BIT  = 24;
  localparam int B_HI    = 23;
  localparam int B_LO    = 18;
  localparam int C_HI    = 17;
  localparam int C_LO    = 12;
  localparam int T_HI    = 11;
  localparam int T_LO    = 5;
  localparam int A_HI    = 4;
  localparam int A_LO    = 0;

  localparam logic [5:0] CBUS_NONE = 6'h23;
  localparam logic [5:0] BBUS_NONE = 6'h23;

  // Equals 33'b000000000100011100011011111100000.
  localparam logic [MIR_W-1:0] NOP_WORD = {4'h0, 2'b00, 1'b0, 1'b0, 1'b0,
                                           BBUS_NONE, CBUS_NONE, 7'b0111111, 5'd0};

  localparam logic [2:0] COND_ALWAYS = 3'd0;
  localparam logic [2:0] COND_Z      = 3'd1;
  localparam logic [2:0] COND_NZ     = 3'd2;
  localparam logic [2:0] COND_CY     = 3'd3;
  localparam logic [2:0] COND_NCY    = 3'd4;

  localparam logic [1:0] FORCE_CLR_CY = 2'b01;
  localparam logic [1:0] FORCE_SET_CY = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_EXEC = 3'd1,
    ST_MEM  = 3'd2,
    ST_WB   = 3'd3,
    ST_BR   = 3'd4
  } state_e;

  // Codes 5..7 never hold.
  function automatic logic cond_holds(input logic [2:0] cond,
                                      input logic       z,
                                      input logic       cy);
    logic res;
    case (cond)
      COND_ALWAYS: res = 1'b1;
      COND_Z:      res = z;
      COND_NZ:     res = ~z;
      COND_CY:     res = cy;
      COND_NCY:    res = ~cy;
      default:     res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mir_cond_eval.sv
// Combinational Ttype decode: branch flag, condition result on the current
// flags, and the Z/CY update mask with the CY force codes.
module mir_cond_eval
  import mir_pkg::*;
(
  input  logic [6:0] ttype_i,
  input  logic       flag_z_i,
  input  logic       flag_cy_i,
  output logic       branch_o,
  output logic       cond_true_o,
  output logic       upd_z_o,
  output logic       upd_cy_o,
  output logic       force_set_o,
  output logic       force_clr_o
);

  // Field split plus condition/force decode.
  always_comb begin
    branch_o    = ttype_i[6];
    cond_true_o = cond_holds(ttype_i[5:3], flag_z_i, flag_cy_i);
    upd_cy_o    = ttype_i[2];
    upd_z_o     = ttype_i[1];
    force_set_o = 1'b0;
    force_clr_o = 1'b0;
    case (ttype_i[1:0])
      FORCE_CLR_CY: force_clr_o = 1'b1;
      FORCE_SET_CY: force_set_o = 1'b1;
      default: begin
        force_set_o = 1'b0;
        force_clr_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mir_sequencer.sv
// Consumer end of the MIR interface: latches one microinstruction, drives the
// datapath selects and sequences EXEC / MEM / WB / BR cycles with Z/CY flags.
module mir_sequencer
  import mir_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [32:0]       mir,
  input  logic              mir_valid,
  output logic              mir_ready,
  input  logic [ADDR_W-1:0] ir_addr,
  output logic [3:0]        alu_op,
  output logic [1:0]        sh_op,
  output logic              kmx,
  output logic [4:0]        a_sel,
  output logic [5:0]        b_sel,
  output logic [5:0]        c_sel,
  input  logic              alu_z,
  input  logic              alu_cy,
  output logic              reg_we,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_target,
  output logic              flag_z,
  output logic              flag_cy,
  output logic              bus_err
);

  localparam int              CNT_W     = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_e              state_q;
  logic [MIR_W-1:0]    mir_q;
  logic [ADDR_W-1:0]   ir_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                alu_z_q;
  logic                alu_cy_q;
  logic                mir_ready_q;
  logic                reg_we_q;
  logic                mem_req_q;
  logic                mem_we_q;
  logic                pc_load_q;
  logic                bus_err_q;
  logic                flag_z_q;
  logic                flag_cy_q;
  logic                flag_z_d;
  logic                flag_cy_d;

  logic                branch_s;
  logic                cond_true_s;
  logic                upd_z_s;
  logic                upd_cy_s;
  logic                force_set_s;
  logic                force_clr_s;
  logic                wr_en_s;

  mir_cond_eval u_cond (
    .ttype_i     (mir_q[T_HI:T_LO]),
    .flag_z_i    (flag_z_q),
    .flag_cy_i   (flag_cy_q),
    .branch_o    (branch_s),
    .cond_true_o (cond_true_s),
    .upd_z_o     (upd_z_s),
    .upd_cy_o    (upd_cy_s),
    .force_set_o (force_set_s),
    .force_clr_o (force_clr_s)
  );

  assign wr_en_s = (mir_q[C_HI:C_LO] != CBUS_NONE);

  // Flag values committed at the end of WB; CY force codes beat the CY mask.
  always_comb begin
    flag_z_d  = flag_z_q;
    flag_cy_d = flag_cy_q;
    if (upd_z_s) begin
      flag_z_d = alu_z_q;
    end else begin
      flag_z_d = flag_z_q;
    end
    if (force_set_s) begin
      flag_cy_d = 1'b1;
    end else if (force_clr_s) begin
      flag_cy_d = 1'b0;
    end else if (upd_cy_s) begin
      flag_cy_d = alu_cy_q;
    end else begin
      flag_cy_d = flag_cy_q;
    end
  end

  // Sequencer FSM with registered strobes and field holding register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mir_q       <= NOP_WORD;
      ir_q        <= '0;
      cnt_q       <= '0;
      alu_z_q     <= 1'b0;
      alu_cy_q    <= 1'b0;
      mir_ready_q <= 1'b1;
      reg_we_q    <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      pc_load_q   <= 1'b0;
      bus_err_q   <= 1'b0;
      flag_z_q    <= 1'b0;
      flag_cy_q   <= 1'b0;
    end else begin
      reg_we_q  <= 1'b0;
      pc_load_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (mir_valid && mir_ready_q) begin
            mir_q       <= mir;
            ir_q        <= ir_addr;
            mir_ready_q <= 1'b0;
            state_q     <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          alu_z_q  <= alu_z;
          alu_cy_q <= alu_cy;
          if (mir_q[MR_BIT] || mir_q[MW_BIT]) begin
            mem_req_q <= 1'b1;
            mem_we_q  <= mir_q[MW_BIT];
            cnt_q     <= CNT_ONE;
            state_q   <= ST_MEM;
          end else if (branch_s) begin
            pc_load_q <= cond_true_s;
            state_q   <= ST_BR;
          end else begin
            reg_we_q <= wr_en_s;
            state_q  <= ST_WB;
          end
        end
        ST_MEM: begin
          // An ack arriving on the limit cycle still completes the access.
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            if (mem_we_q) begin
              mir_ready_q <= 1'b1;
              state_q     <= ST_IDLE;
            end else begin
              reg_we_q <= wr_en_s;
              state_q  <= ST_WB;
            end
          end else if (cnt_q == CNT_LIMIT) begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            bus_err_q   <= 1'b1;
            mir_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        ST_WB: begin
          flag_z_q    <= flag_z_d;
          flag_cy_q   <= flag_cy_d;
          mir_ready_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
        ST_BR: begin
          mir_ready_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
        default: begin
          mem_req_q   <= 1'b0;
          mem_we_q    <= 1'b0;
          mir_ready_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign mir_ready = mir_ready_q;
  assign alu_op    = mir_q[ALU_HI:ALU_LO];
  assign sh_op     = mir_q[SH_HI:SH_LO];
  assign kmx       = mir_q[KMX_BIT];
  assign a_sel     = mir_q[A_HI:A_LO];
  assign b_sel     = mir_q[B_HI:B_LO];
  assign c_sel     = mir_q[C_HI:C_LO];
  assign reg_we    = reg_we_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = ir_q;
  assign pc_load   = pc_load_q;
  assign pc_target = ir_q;
  assign flag_z    = flag_z_q;
  assign flag_cy   = flag_cy_q;
  assign bus_err   = bus_err_q;

endmodule
